// File: rtl/control_pkg.sv
// Shared ISA definitions for the single-cycle core: instruction/opcode widths,
// opcode and ALU operation encodings, and the decoded strobe bundle.
package control_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 4;
    localparam int ALU_OP_W = 3;

    localparam logic [OPCODE_W-1:0] OP_HALT = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_LSL  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'h4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_LSL = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd2;

    typedef struct packed {
        logic                halt;
        logic                reg_write_en;
        logic                alu_use_imm;
        logic                is_beq;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPCODE_W];
    endfunction

    function automatic logic is_legal_opcode(input logic [OPCODE_W-1:0] opcode);
        return opcode <= OP_BEQ;
    endfunction

endpackage

// File: rtl/control_if.sv
// Instruction-in / control-strobes-out bundle for the decoder.
// The illegal flag exists only when CONTROL_ILLEGAL_TRAP_EN is defined.
interface control_if;
    import control_pkg::*;

    logic [INSTR_W-1:0]  instr;
    logic                halted;
    logic                reg_write_en;
    logic                alu_use_imm;
    logic                is_beq;
    logic [ALU_OP_W-1:0] alu_op;
`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic                illegal;
`endif

    modport master (
        output instr,
        input  halted,
        input  reg_write_en,
        input  alu_use_imm,
        input  is_beq,
        input  alu_op
`ifdef CONTROL_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );

    modport slave (
        input  instr,
        output halted,
        output reg_write_en,
        output alu_use_imm,
        output is_beq,
        output alu_op
`ifdef CONTROL_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

endinterface

// File: rtl/control_opcode_decoder.sv
// Purely combinational opcode-to-strobe table; unlisted opcodes decode as NOP.
module control_opcode_decoder
    import control_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        ctrl_o.alu_op = ALU_ADD;
        case (opcode_i)
            OP_HALT: ctrl_o.halt = 1'b1;
            OP_ADD:  ctrl_o.reg_write_en = 1'b1;
            OP_LSL: begin
                ctrl_o.reg_write_en = 1'b1;
                ctrl_o.alu_op       = ALU_LSL;
            end
            OP_ADDI: begin
                ctrl_o.reg_write_en = 1'b1;
                ctrl_o.alu_use_imm  = 1'b1;
            end
            // BEQ runs a subtract so the PC logic can test the zero flag
            OP_BEQ: begin
                ctrl_o.is_beq = 1'b1;
                ctrl_o.alu_op = ALU_SUB;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/control.sv
// Instruction decoder top: combinational decode plus a sticky halt latch.
// Define CONTROL_ILLEGAL_TRAP_EN to add the sticky illegal-opcode trap.
module control
    import control_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    control_if.slave bus
);

    logic [OPCODE_W-1:0] opcode;
    ctrl_t               decodedCtrl;
    logic                halt_q;
    logic                halt_d;

    assign opcode = opcode_of(bus.instr);

    control_opcode_decoder u_decoder (
        .opcode_i (opcode),
        .ctrl_o   (decodedCtrl)
    );

`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_d;
    logic illegalSet;

    // A trap is only taken while running; once halted the core ignores instr
    assign illegalSet = !is_legal_opcode(opcode) && !halt_q;
    assign illegal_d  = illegal_q | illegalSet;
    assign halt_d     = halt_q | decodedCtrl.halt | illegalSet;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign halt_d = halt_q | decodedCtrl.halt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign bus.halted       = decodedCtrl.halt | halt_q;
    assign bus.reg_write_en = decodedCtrl.reg_write_en & ~halt_q;
    assign bus.alu_use_imm  = decodedCtrl.alu_use_imm & ~halt_q;
    assign bus.is_beq       = decodedCtrl.is_beq & ~halt_q;
    assign bus.alu_op       = halt_q ? ALU_ADD : decodedCtrl.alu_op;

endmodule

// File: tb/tb_control.sv
// Directed self-checking bench for the control decoder and its halt latch.
// Covers the illegal trap as well when CONTROL_ILLEGAL_TRAP_EN is defined.
module tb_control;
    import control_pkg::*;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   failCount;

    control_if bus ();

    control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [INSTR_W-1:0] instr);
        bus.instr = instr;
        #1;
    endtask

    // Single clock pulse; the clock idles low so decode checks see no edges
    task automatic tickClock();
        #2 clk = 1'b1;
        #2 clk = 1'b0;
        #1;
    endtask

    task automatic checkDecode(input string tag, input logic expHalted, input logic expWrite,
                               input logic expImm, input logic expBeq,
                               input logic [ALU_OP_W-1:0] expAluOp);
        checkOutput({tag, ".halted"},       8'(bus.halted),       8'(expHalted));
        checkOutput({tag, ".reg_write_en"}, 8'(bus.reg_write_en), 8'(expWrite));
        checkOutput({tag, ".alu_use_imm"},  8'(bus.alu_use_imm),  8'(expImm));
        checkOutput({tag, ".is_beq"},       8'(bus.is_beq),       8'(expBeq));
        checkOutput({tag, ".alu_op"},       8'(bus.alu_op),       8'(expAluOp));
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        clk        = 1'b0;
        rst_n      = 1'b0;
        bus.instr  = 16'h0000;
        #3 rst_n = 1'b1;
        #2;

        applyStimulus(16'h0000);
        checkDecode("halt_comb", 1, 0, 0, 0, 3'd0);
        applyStimulus(16'h1000);
        checkDecode("add", 0, 1, 0, 0, 3'd0);
        applyStimulus(16'h2000);
        checkDecode("lsl", 0, 1, 0, 0, 3'd1);
        applyStimulus(16'h3000);
        checkDecode("addi", 0, 1, 1, 0, 3'd0);
        applyStimulus(16'h4000);
        checkDecode("beq", 0, 0, 0, 1, 3'd2);
        applyStimulus(16'h4ABC);
        checkDecode("beq_lowbits", 0, 0, 0, 1, 3'd2);
        applyStimulus(16'hF000);
        checkDecode("illegal_F", 0, 0, 0, 0, 3'd0);
        applyStimulus(16'h5FFF);
        checkDecode("illegal_5", 0, 0, 0, 0, 3'd0);

        // Latch a halt, then confirm every later instruction is suppressed
        applyStimulus(16'h0000);
        tickClock();
        applyStimulus(16'h1000);
        checkDecode("halted_add", 1, 0, 0, 0, 3'd0);
        applyStimulus(16'h4000);
        checkDecode("halted_beq", 1, 0, 0, 0, 3'd0);
        applyStimulus(16'h2000);
        checkDecode("halted_lsl", 1, 0, 0, 0, 3'd0);
        tickClock();
        checkDecode("halted_sticky", 1, 0, 0, 0, 3'd0);

        applyStimulus(16'h1000);
        rst_n = 1'b0;
        #1;
        checkDecode("async_reset", 0, 1, 0, 0, 3'd0);
        rst_n = 1'b1;
        #1;
        checkDecode("after_reset", 0, 1, 0, 0, 3'd0);
        tickClock();
        checkDecode("add_no_latch", 0, 1, 0, 0, 3'd0);

        // A HALT edge during reset must not latch
        rst_n = 1'b0;
        applyStimulus(16'h0000);
        tickClock();
        applyStimulus(16'h3000);
        rst_n = 1'b1;
        #1;
        checkDecode("reset_wins", 0, 1, 1, 0, 3'd0);

`ifdef CONTROL_ILLEGAL_TRAP_EN
        checkOutput("illegal_reset", 8'(bus.illegal), 8'd0);
        applyStimulus(16'hF000);
        checkOutput("illegal_pre_edge", 8'(bus.illegal), 8'd0);
        checkOutput("halted_pre_edge", 8'(bus.halted), 8'd0);
        tickClock();
        checkOutput("illegal_set", 8'(bus.illegal), 8'd1);
        checkOutput("illegal_halts", 8'(bus.halted), 8'd1);
        applyStimulus(16'h1000);
        checkDecode("trap_add", 1, 0, 0, 0, 3'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("illegal_clear", 8'(bus.illegal), 8'd0);
        checkOutput("trap_halt_clear", 8'(bus.halted), 8'd0);
        rst_n = 1'b1;
        applyStimulus(16'h0000);
        tickClock();
        applyStimulus(16'h7000);
        tickClock();
        checkOutput("no_trap_when_halted", 8'(bus.illegal), 8'd0);
        checkOutput("still_halted", 8'(bus.halted), 8'd1);
`else
        applyStimulus(16'hF000);
        tickClock();
        applyStimulus(16'h1000);
        checkDecode("illegal_is_nop", 0, 1, 0, 0, 3'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
